dmem_write_buffer: RTL and testbench
====================================

Name: dmem_write_buffer

Overview:
- Posted-store buffer between the MIPS core's data-memory port (memwrite/dataadr/writedata) and a slower data memory with a req/ack handshake.
- Captures CPU stores in a small in-order FIFO and drains them one at a time to memory.
- Stalls the core only when the buffer is full.
- Forwards buffered data to CPU loads whose address matches a pending store.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cpu_memwrite  in  1  store strobe from the core; sampled each rising edge.
- cpu_adr  in  AW  store address (dataadr).
- cpu_wdata  in  DW  store data (writedata).
- cpu_stall  out  1  core must hold the store and retry; combinational, equals cpu_memwrite & full.
- cpu_radr  in  AW  load address for the forwarding lookup.
- fwd_hit  out  1  a pending entry matches cpu_radr; combinational.
- fwd_data  out  DW  data of the youngest matching entry; 0 when fwd_hit=0.
- mem_req  out  1  head entry valid and offered to memory.
- mem_adr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_ack  in  1  memory accepted the head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, all valid bits cleared. Outputs go to mem_req=0, mem_adr=0, mem_wdata=0, fwd_hit=0, fwd_data=0, cpu_stall=0 (when cpu_memwrite=0), empty=1, full=0.
  - Reset mid-drain discards all entries, including a head whose ack never arrived. No partial memory write is retried.
- Storage: circular buffer. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. count is tracked separately.
- Push: on the clk edge where cpu_memwrite=1 and full=0.
  - Entry {cpu_adr, cpu_wdata} is written at wr_ptr; wr_ptr increments.
  - When full=1, no push occurs even if the same edge pops; cpu_stall stays high that cycle. This is a deliberate choice to avoid a full-bypass path.
- Drain: mem_req = !empty, driven from registered state only. mem_adr/mem_wdata always show the rd_ptr entry, and both are 0 when empty.
  - Latency: a store pushed at edge N appears on mem_req at cycle N+1 if the buffer was empty.
  - Handshake: mem_adr/mem_wdata hold stable while mem_req=1 and mem_ack=0.
  - Pop occurs on the edge where mem_req=1 and mem_ack=1; rd_ptr increments. mem_ack while empty is ignored.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. With count==1, the new entry becomes the head on the next cycle.
- Forwarding:
  - All valid entries compare their full AW-bit address against cpu_radr.
  - Priority goes to the youngest match, i.e. nearest wr_ptr-1 going backwards.
  - The head entry takes part even while being acked. An entry pushed on the current edge does not take part (registered storage only).
- Ordering: stores drain strictly in program order. Without the optional feature, duplicate addresses occupy separate entries.

Optional Feature:
- Macro: WBUF_COALESCE_EN.
- Defined: a push whose cpu_adr equals the youngest valid entry's address overwrites that entry's data in place. No allocation occurs, and count/wr_ptr are unchanged.
  - Coalescing is suppressed when that entry is the head with mem_req=1; the store then allocates normally.
  - When full, a coalescing store is accepted and cpu_stall=0 for it.
- Undefined: every accepted store allocates a new entry. The coalescing comparator is absent.

Decomposition:
- Package mips_mem_pkg:
  - constants ADDR_W=32, DATA_W=32.
  - typedef wbuf_entry_t {valid, adr[ADDR_W-1:0], data[DATA_W-1:0]}.
  - function for youngest-first index rotation.
- Sub-module wbuf_fwd_match: combinational DEPTH-way address compare plus priority select.
  - Inputs: entries, wr_ptr, cpu_radr.
  - Outputs: fwd_hit, fwd_data.
  - Also reused by the coalescing check.

Test Plan:
- Reset then single store adr=0x54 data=7 with mem_ack tied high → mem_req=1, mem_adr=0x54, mem_wdata=7 next cycle; popped one cycle later; empty=1.
- Four stores (0x10..0x1C, data 1..4) with mem_ack=0 → full=1 after the fourth; fifth store with cpu_memwrite=1 gives cpu_stall=1; after one ack, the fifth is accepted the next edge; drain order is 1,2,3,4,5.
- Stores 0x20←5 then 0x20←9, with cpu_radr=0x20 and mem_ack=0 → fwd_hit=1, fwd_data=9; cpu_radr=0x24 → fwd_hit=0, fwd_data=0.
- Hold mem_ack=0 for 3 cycles with one entry → mem_adr/mem_wdata stable for all 3; ack on the 4th cycle → pop with simultaneous push; count stays 1.
- Assert reset=0 asynchronously mid-drain with 3 entries → mem_req, count, fwd_hit go 0 immediately without a clock; empty=1.
- With WBUF_COALESCE_EN, stores 0x40←1 (head, requesting), 0x44←2, 0x44←3 → count=2; drained values are 1 then 3.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared widths, entry type and index helper for the data-memory write buffer
package mips_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;

  // k=0 is the youngest entry (wr_ptr-1); k grows towards older entries. depth is a power of two.
  function automatic int unsigned wbuf_rot_idx(input int unsigned wr_ptr,
                                               input int unsigned k,
                                               input int unsigned depth);
    return (wr_ptr + depth - 1 - k) & (depth - 1);
  endfunction

endpackage

// File: rtl/dmem_write_buffer_if.sv
// rtl/dmem_write_buffer_if.sv - core-side store/load lookup and memory-side req/ack bundle
interface dmem_write_buffer_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cpu_memwrite;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [AW-1:0] cpu_radr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_req;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  modport slave (
    input  cpu_memwrite, cpu_adr, cpu_wdata, cpu_radr, mem_ack,
    output cpu_stall, fwd_hit, fwd_data, mem_req, mem_adr, mem_wdata, count, empty, full
  );

  modport master (
    output cpu_memwrite, cpu_adr, cpu_wdata, cpu_radr, mem_ack,
    input  cpu_stall, fwd_hit, fwd_data, mem_req, mem_adr, mem_wdata, count, empty, full
  );

endinterface

// File: rtl/wbuf_fwd_match.sv
// rtl/wbuf_fwd_match.sv - DEPTH-way address compare with youngest-match priority select
module wbuf_fwd_match
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wbuf_entry_t                 entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]    wr_ptr_i,
  input  logic [ADDR_W-1:0]           radr_i,
  output logic                        hit_o,
  output logic [DATA_W-1:0]           data_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last (youngest) match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = PW'(wbuf_rot_idx(32'(wr_ptr_i), k, DEPTH));
      if (entries_i[idx].valid && (entries_i[idx].adr == radr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - posted-store FIFO between core data port and req/ack data memory
// Optional store coalescing into the youngest entry: define WBUF_COALESCE_EN.
module dmem_write_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_write_buffer_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbuf_entry_t       entries_q [DEPTH];
  wbuf_entry_t       head;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              empty, full, push, pop, coalesce;
  logic [DATA_W-1:0] fwd_data_w;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = !empty && bus.mem_ack;
  assign push  = bus.cpu_memwrite && !full && !coalesce;

`ifdef WBUF_COALESCE_EN
  logic [PW-1:0] coal_idx;
  assign coal_idx = wr_ptr_q - 1'b1;
  // With count==1 the youngest entry is the requesting head, so it must not be rewritten.
  assign coalesce = bus.cpu_memwrite && (count_q >= CW'(2)) &&
                    (entries_q[coal_idx].adr == ADDR_W'(bus.cpu_adr));
`else
  assign coalesce = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        entries_q[wr_ptr_q] <= '{valid: 1'b1,
                                 adr:   ADDR_W'(bus.cpu_adr),
                                 data:  DATA_W'(bus.cpu_wdata)};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        entries_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
`ifdef WBUF_COALESCE_EN
      if (coalesce) entries_q[coal_idx].data <= DATA_W'(bus.cpu_wdata);
`endif
    end
  end

  assign head          = entries_q[rd_ptr_q];
  assign bus.mem_req   = !empty;
  assign bus.mem_adr   = empty ? '0 : AW'(head.adr);
  assign bus.mem_wdata = empty ? '0 : DW'(head.data);
  assign bus.cpu_stall = bus.cpu_memwrite && full && !coalesce;
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;

  wbuf_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .entries_i (entries_q),
    .wr_ptr_i  (wr_ptr_q),
    .radr_i    (ADDR_W'(bus.cpu_radr)),
    .hit_o     (bus.fwd_hit),
    .data_o    (fwd_data_w)
  );
  assign bus.fwd_data = DW'(fwd_data_w);

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - randomized and directed checks against a queue model of the write buffer
module tb_dmem_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_write_buffer_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

  dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ent_t          q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          mw, ack;
  logic [AW-1:0] adr, radr;
  logic [DW-1:0] wd;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_coalesce();
`ifdef WBUF_COALESCE_EN
    return mw && (q.size() >= 2) && (q[q.size()-1].adr == adr);
`else
    return 1'b0;
`endif
  endfunction

  task automatic apply_inputs();
    bus.cpu_memwrite = mw;
    bus.cpu_adr      = adr;
    bus.cpu_wdata    = wd;
    bus.cpu_radr     = radr;
    bus.mem_ack      = ack;
  endtask

  task automatic check_all();
    logic          hit;
    logic [DW-1:0] fdat;
    logic          nonempty;
    hit      = 1'b0;
    fdat     = '0;
    nonempty = (q.size() != 0);
    foreach (q[i]) if (q[i].adr == radr) begin
      hit  = 1'b1;
      fdat = q[i].data;
    end
    check_eq("mem_req",   64'(bus.mem_req),   64'(nonempty));
    check_eq("mem_adr",   64'(bus.mem_adr),   nonempty ? 64'(q[0].adr)  : 64'd0);
    check_eq("mem_wdata", 64'(bus.mem_wdata), nonempty ? 64'(q[0].data) : 64'd0);
    check_eq("count",     64'(bus.count),     64'(q.size()));
    check_eq("empty",     64'(bus.empty),     64'(q.size() == 0));
    check_eq("full",      64'(bus.full),      64'(q.size() == DEPTH));
    check_eq("cpu_stall", 64'(bus.cpu_stall), 64'(mw && (q.size() == DEPTH) && !exp_coalesce()));
    check_eq("fwd_hit",   64'(bus.fwd_hit),   64'(hit));
    check_eq("fwd_data",  64'(bus.fwd_data),  64'(fdat));
  endtask

  task automatic model_step();
    logic do_pop, do_push, do_coal;
    ent_t e;
    do_pop  = (q.size() != 0) && ack;
    do_coal = exp_coalesce();
    do_push = mw && !do_coal && (q.size() < DEPTH);
    if (do_coal) begin
      e      = q[q.size()-1];
      e.data = wd;
      q[q.size()-1] = e;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{adr, wd});
  endtask

  // One clock: model absorbs the edge, new inputs go in after it, outputs checked on the falling edge.
  task automatic cycle(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [AW-1:0] ra, input logic k);
    @(posedge clk);
    model_step();
    #1;
    mw = m; adr = a; wd = d; radr = ra; ack = k;
    apply_inputs();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    mw = 1'b0; adr = '0; wd = '0; radr = '0; ack = 1'b0;
    apply_inputs();
    reset = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // single store, memory always ready
    cycle(1'b1, 32'h54, 32'd7, 32'h54, 1'b1);
    cycle(1'b0, 32'h0,  32'd0, 32'h54, 1'b1);
    cycle(1'b0, 32'h0,  32'd0, 32'h54, 1'b1);

    // fill to full, stall the fifth, then one ack lets it in
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h10 + 32'(4*i), 32'(i+1), 32'h18, 1'b0);
    cycle(1'b1, 32'h20, 32'd5, 32'h20, 1'b0);
    cycle(1'b1, 32'h20, 32'd5, 32'h20, 1'b0);
    cycle(1'b1, 32'h20, 32'd5, 32'h20, 1'b1);
    cycle(1'b1, 32'h20, 32'd5, 32'h20, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 32'd0, 32'h20, 1'b1);

    // youngest-match forwarding, then a miss
    cycle(1'b1, 32'h20, 32'd5, 32'h20, 1'b0);
    cycle(1'b1, 32'h20, 32'd9, 32'h20, 1'b0);
    cycle(1'b0, 32'h0,  32'd0, 32'h20, 1'b0);
    cycle(1'b0, 32'h0,  32'd0, 32'h24, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'd0, 32'h24, 1'b1);

    // head held stable under back-pressure, then pop with simultaneous push
    cycle(1'b1, 32'h30, 32'hA5, 32'h30, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'd0, 32'h30, 1'b0);
    cycle(1'b1, 32'h34, 32'hB6, 32'h30, 1'b1);
    cycle(1'b0, 32'h0,  32'd0,  32'h34, 1'b1);
    cycle(1'b0, 32'h0,  32'd0,  32'h34, 1'b0);

`ifdef WBUF_COALESCE_EN
    cycle(1'b1, 32'h40, 32'd1, 32'h44, 1'b0);
    cycle(1'b1, 32'h44, 32'd2, 32'h44, 1'b0);
    cycle(1'b1, 32'h44, 32'd3, 32'h44, 1'b0);
    cycle(1'b0, 32'h0,  32'd0, 32'h44, 1'b1);
    cycle(1'b0, 32'h0,  32'd0, 32'h44, 1'b1);
    cycle(1'b0, 32'h0,  32'd0, 32'h44, 1'b1);
`endif

    // randomized traffic at three memory speeds
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 200; n++) begin
        cycle($urandom_range(0, 99) < 60,
              32'h40 + 32'(4 * $urandom_range(0, 3)),
              32'($urandom),
              32'h40 + 32'(4 * $urandom_range(0, 4)),
              $urandom_range(0, 99) < (p == 0 ? 15 : (p == 1 ? 50 : 90)));
      end
    end

    // asynchronous reset mid-drain with three entries
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 32'd0, 32'h60, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h60 + 32'(4*i), 32'(10+i), 32'h60, 1'b0);
    cycle(1'b0, 32'h0, 32'd0, 32'h60, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    check_eq("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check_eq("rst_count",   64'(bus.count),   64'd0);
    check_eq("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    check_eq("rst_empty",   64'(bus.empty),   64'd1);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 32'h70, 32'd42, 32'h70, 1'b0);
    cycle(1'b0, 32'h0,  32'd0,  32'h70, 1'b1);
    cycle(1'b0, 32'h0,  32'd0,  32'h70, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
